seven_segment_reader: RTL and testbench

Recovers 4-bit digit codes from a multiplexed, strobed 7-segment display bus; it is the inverse of the universal BCD-to-7-segment decoder. It samples segment lines and one-hot digit strobes, waits for each digit's glyph to be stable, then maps the glyph back to a code using the same 3-bit glyph-set selector. Once every digit position has been captured, it presents one display frame through a valid/ready handshake. It sits between a scanned display bus, from a decoder or an external instrument, and downstream logic.

---
 rtl/seven_segment_reader.sv | 195 +++++++++++++++++++
 tb/tb_seven_segment_reader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_reader.sv
// Recovers digit codes from a scanned, strobed 7-segment display bus and
// presents each complete display frame through a valid/ready handshake.
module seven_segment_reader #(
    parameter int DIGITS = 4,
    parameter int STABLE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg,
    input  logic                  al,
    input  logic [2:0]            version,
    input  logic [DIGITS-1:0]     strobe,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     err,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  overrun
);

    localparam int CW = $clog2(STABLE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);
    localparam logic [CW-1:0] CNT_HIT = CW'(STABLE - 1);

    logic [6:0]        glyph;
    logic [DIGITS-1:0] s1_strobe;
    logic [6:0]        s1_glyph;
    logic [CW-1:0]     cnt;
    logic              captured;
    logic [DIGITS-1:0] seen;
    logic [DIGITS-1:0] seen_next;
    logic [3:0]        shadow_code [DIGITS];
    logic [DIGITS-1:0] shadow_blank;
    logic [DIGITS-1:0] shadow_err;
    logic              same;
    logic              do_capture;
    logic              complete;
    logic [5:0]        dec;

    // Result layout: {blank, err, code[3:0]}.
    function automatic logic [5:0] decode(input logic [2:0] ver, input logic [6:0] g);
        logic       vhit;
        logic       bhit;
        logic [3:0] vcode;
        logic [3:0] bcode;
        vhit  = 1'b1;
        vcode = 4'd0;
        // Letter glyphs are checked first so hex 7C (B) wins over the base 6.
        case (ver)
            3'd1: case (g)
                7'h58: vcode = 4'hA;
                7'h4C: vcode = 4'hB;
                7'h62: vcode = 4'hC;
                7'h69: vcode = 4'hD;
                7'h78: vcode = 4'hE;
                default: vhit = 1'b0;
            endcase
            3'd2: case (g)
                7'h5C: vcode = 4'hA;
                7'h63: vcode = 4'hB;
                7'h01: vcode = 4'hC;
                7'h40: vcode = 4'hD;
                7'h08: vcode = 4'hE;
                default: vhit = 1'b0;
            endcase
            3'd4: case (g)
                7'h08: vcode = 4'hA;
                7'h48: vcode = 4'hB;
                7'h49: vcode = 4'hC;
                7'h41: vcode = 4'hD;
                7'h01: vcode = 4'hE;
                default: vhit = 1'b0;
            endcase
            3'd5: case (g)
                7'h40: vcode = 4'hA;
                7'h38: vcode = 4'hB;
                7'h39: vcode = 4'hC;
                7'h31: vcode = 4'hD;
                7'h79: vcode = 4'hE;
                default: vhit = 1'b0;
            endcase
            3'd6: case (g)
                7'h40: vcode = 4'hA;
                7'h79: vcode = 4'hB;
                7'h76: vcode = 4'hC;
                7'h38: vcode = 4'hD;
                7'h73: vcode = 4'hE;
                default: vhit = 1'b0;
            endcase
            3'd7: case (g)
                7'h77: vcode = 4'hA;
                7'h7C: vcode = 4'hB;
                7'h39: vcode = 4'hC;
                7'h5E: vcode = 4'hD;
                7'h79: vcode = 4'hE;
                7'h71: vcode = 4'hF;
                default: vhit = 1'b0;
            endcase
            default: vhit = 1'b0;
        endcase

        bhit  = 1'b1;
        bcode = 4'd0;
        case (g)
            7'h3F:        bcode = 4'd0;
            7'h06:        bcode = 4'd1;
            7'h5B:        bcode = 4'd2;
            7'h4F:        bcode = 4'd3;
            7'h66:        bcode = 4'd4;
            7'h6D:        bcode = 4'd5;
            7'h7D, 7'h7C: bcode = 4'd6;
            7'h27, 7'h07: bcode = 4'd7;
            7'h7F:        bcode = 4'd8;
            7'h6F, 7'h67: bcode = 4'd9;
            default:      bhit  = 1'b0;
        endcase

        if (g == 7'h00)
            return 6'b10_0000;
        if (vhit)
            return {2'b00, vcode};
        if (bhit)
            return {2'b00, bcode};
        return 6'b01_0000;
    endfunction

    assign glyph = seg ^ {7{~al}};

    always_comb begin
        same       = $onehot(s1_strobe) && (strobe == s1_strobe) && (glyph == s1_glyph);
        do_capture = same && !captured && (cnt == CNT_HIT);
        complete   = &seen;
        dec        = decode(version, glyph);
        seen_next  = complete ? '0 : seen;
        if (do_capture)
            seen_next = seen_next | s1_strobe;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_strobe    <= '0;
            s1_glyph     <= '0;
            cnt          <= '0;
            captured     <= 1'b0;
            seen         <= '0;
            shadow_blank <= '0;
            shadow_err   <= '0;
            for (int i = 0; i < DIGITS; i++)
                shadow_code[i] <= 4'd0;
            value        <= '0;
            blank        <= '0;
            err          <= '0;
            frame_valid  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            s1_strobe <= strobe;
            s1_glyph  <= glyph;

            if (same) begin
                if (cnt != CNT_MAX)
                    cnt <= cnt + 1'b1;
                if (do_capture)
                    captured <= 1'b1;
            end else begin
                cnt      <= '0;
                captured <= 1'b0;
            end

            for (int i = 0; i < DIGITS; i++) begin
                if (do_capture && s1_strobe[i]) begin
                    shadow_code[i]  <= dec[3:0];
                    shadow_blank[i] <= dec[5];
                    shadow_err[i]   <= dec[4];
                end
            end
            seen <= seen_next;

            overrun <= 1'b0;
            if (complete) begin
                if (!frame_valid || frame_ready) begin
                    for (int i = 0; i < DIGITS; i++)
                        value[4*i +: 4] <= shadow_code[i];
                    blank       <= shadow_blank;
                    err         <= shadow_err;
                    frame_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader: a glyph-history reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_seven_segment_reader;

    localparam int DIGITS = 4;
    localparam int STABLE = 2;
    localparam int H      = STABLE + 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [6:0]          seg;
    logic                al;
    logic [2:0]          version;
    logic [DIGITS-1:0]   strobe;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   blank;
    logic [DIGITS-1:0]   err;
    logic                frame_valid;
    logic                frame_ready;
    logic                overrun;

    int errors = 0;
    int checks = 0;
    int ovr_cnt = 0;

    seven_segment_reader #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
        .clk(clk), .rst(rst), .seg(seg), .al(al), .version(version),
        .strobe(strobe), .value(value), .blank(blank), .err(err),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    logic [6:0] primary [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h27, 7'h7F, 7'h6F};
    logic [6:0] letters [8][6] = '{
        '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
        '{7'h58, 7'h4C, 7'h62, 7'h69, 7'h78, 7'h00},
        '{7'h5C, 7'h63, 7'h01, 7'h40, 7'h08, 7'h00},
        '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
        '{7'h08, 7'h48, 7'h49, 7'h41, 7'h01, 7'h00},
        '{7'h40, 7'h38, 7'h39, 7'h31, 7'h79, 7'h00},
        '{7'h40, 7'h79, 7'h76, 7'h38, 7'h73, 7'h00},
        '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71}
    };

    // Returns {blank, err, code}.
    function automatic logic [5:0] ref_decode(input logic [2:0] v, input logic [6:0] g);
        if (g == 7'h00) return 6'b10_0000;
        for (int k = 0; k < 6; k++)
            if (letters[v][k] != 7'h00 && letters[v][k] == g)
                return {2'b00, 4'(10 + k)};
        for (int d = 0; d < 10; d++)
            if (primary[d] == g) return {2'b00, 4'(d)};
        if (g == 7'h7C) return 6'd6;
        if (g == 7'h07) return 6'd7;
        if (g == 7'h67) return 6'd9;
        return 6'b01_0000;
    endfunction

    // Reference model: a capture is the STABLE+1'th identical one-hot sample
    // following a different sample.
    logic [DIGITS+6:0]   hist [H];
    logic [3:0]          m_code [DIGITS];
    logic [DIGITS-1:0]   m_blank, m_err, m_seen;
    logic [4*DIGITS-1:0] exp_value;
    logic [DIGITS-1:0]   exp_blank, exp_err;
    logic                exp_fv, exp_ovr, m_cap;
    logic [5:0]          m_dec;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < H; j++) hist[j] = '0;
            for (int i = 0; i < DIGITS; i++) m_code[i] = 4'd0;
            m_blank = '0; m_err = '0; m_seen = '0;
            exp_value = '0; exp_blank = '0; exp_err = '0;
            exp_fv = 1'b0; exp_ovr = 1'b0;
        end else begin
            exp_ovr = 1'b0;
            if (&m_seen) begin
                if (!exp_fv || frame_ready) begin
                    for (int i = 0; i < DIGITS; i++) exp_value[4*i +: 4] = m_code[i];
                    exp_blank = m_blank;
                    exp_err   = m_err;
                    exp_fv    = 1'b1;
                end else begin
                    exp_ovr = 1'b1;
                end
                m_seen = '0;
            end else if (exp_fv && frame_ready) begin
                exp_fv = 1'b0;
            end

            for (int j = H - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = {strobe, seg ^ {7{~al}}};

            m_cap = $onehot(hist[0][DIGITS+6:7]) && (hist[STABLE+1] != hist[0]);
            for (int j = 1; j <= STABLE; j++)
                if (hist[j] != hist[0]) m_cap = 1'b0;
            if (m_cap) begin
                m_dec = ref_decode(version, hist[0][6:0]);
                for (int i = 0; i < DIGITS; i++)
                    if (hist[0][7+i]) begin
                        m_code[i]  = m_dec[3:0];
                        m_blank[i] = m_dec[5];
                        m_err[i]   = m_dec[4];
                        m_seen[i]  = 1'b1;
                    end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("model value", 32'(value), 32'(exp_value));
            check("model blank", 32'(blank), 32'(exp_blank));
            check("model err", 32'(err), 32'(exp_err));
            check("model frame_valid", 32'(frame_valid), 32'(exp_fv));
            check("model overrun", 32'(overrun), 32'(exp_ovr));
            if (overrun) ovr_cnt++;
        end
    end

    task automatic show(input int idx, input logic [6:0] g, input int cycles);
        strobe = '0;
        strobe[idx] = 1'b1;
        seg = g ^ {7{~al}};
        repeat (cycles) @(negedge clk);
    endtask

    task automatic frame(input logic [6:0] g0, input logic [6:0] g1,
                         input logic [6:0] g2, input logic [6:0] g3);
        show(0, g0, 4);
        show(1, g1, 4);
        show(2, g2, 4);
        show(3, g3, 4);
        strobe = '0;
        @(negedge clk);
    endtask

    task automatic accept();
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_frame(input string name, input logic [15:0] v,
                                input logic [3:0] b, input logic [3:0] e);
        check({name, " valid"}, 32'(frame_valid), 32'd1);
        check({name, " value"}, 32'(value), 32'(v));
        check({name, " blank"}, 32'(blank), 32'(b));
        check({name, " err"}, 32'(err), 32'(e));
    endtask

    int ovr0;

    initial begin
        rst = 1'b1; seg = '0; al = 1'b1; version = 3'd0;
        strobe = '0; frame_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset value", 32'(value), 32'd0);
        check("reset valid", 32'(frame_valid), 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);

        frame(7'h06, 7'h5B, 7'h4F, 7'h66);
        expect_frame("basic", 16'h4321, 4'b0000, 4'b0000);
        accept();
        check("accept drops valid", 32'(frame_valid), 32'd0);

        al = 1'b0; version = 3'd7;
        frame(7'h77, 7'h7C, 7'h39, 7'h71);
        expect_frame("hex active-low", 16'hFCBA, 4'b0000, 4'b0000);
        accept();

        version = 3'd0;
        frame(7'h7C, 7'h06, 7'h5B, 7'h3F);
        expect_frame("7C as six", 16'h0216, 4'b0000, 4'b0000);
        accept();

        al = 1'b1;
        show(0, 7'h06, 4);
        show(1, 7'h5B, 4);
        show(2, 7'h4F, 2);
        strobe = 4'b0011; seg = 7'h7F;
        repeat (4) @(negedge clk);
        show(3, 7'h66, 4);
        check("short dwell no frame", 32'(frame_valid), 32'd0);
        show(2, 7'h7F, 4);
        strobe = '0;
        @(negedge clk);
        expect_frame("redwell", 16'h4821, 4'b0000, 4'b0000);
        accept();

        version = 3'd1;
        frame(7'h58, 7'h00, 7'h6D, 7'h7E);
        expect_frame("blank err", 16'h050A, 4'b0010, 4'b1000);
        accept();

        version = 3'd0;
        frame(7'h3F, 7'h6D, 7'h7D, 7'h27);
        expect_frame("overrun first", 16'h7650, 4'b0000, 4'b0000);
        ovr0 = ovr_cnt;
        frame(7'h7F, 7'h6F, 7'h67, 7'h07);
        check("overrun pulses", 32'(ovr_cnt - ovr0), 32'd1);
        expect_frame("kept old frame", 16'h7650, 4'b0000, 4'b0000);
        accept();
        check("accept after overrun", 32'(frame_valid), 32'd0);

        frame(7'h06, 7'h06, 7'h06, 7'h06);
        check("pre-reset valid", 32'(frame_valid), 32'd1);
        show(0, 7'h3F, 1);
        #1 rst = 1'b1;
        #1;
        check("async rst value", 32'(value), 32'd0);
        check("async rst blank", 32'(blank), 32'd0);
        check("async rst err", 32'(err), 32'd0);
        check("async rst valid", 32'(frame_valid), 32'd0);
        check("async rst overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        frame(7'h6D, 7'h66, 7'h4F, 7'h5B);
        expect_frame("after reset", 16'h2345, 4'b0000, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
